// File: rtl/motor_pwm_stage_if.sv
// Bus between the movement logic and the PWM stage: direction codes and duty
// factors in, H-bridge IN pins, PWM enables and status flags out.
interface motor_pwm_stage_if;
    logic [1:0]  dir_a;
    logic [1:0]  dir_b;
    logic [11:0] duty_a;
    logic [11:0] duty_b;
    logic [1:0]  in_a;
    logic [1:0]  in_b;
    logic        pwm_a;
    logic        pwm_b;
    logic        period_tick;
    logic        dead_a;
    logic        dead_b;

    modport master (
        output dir_a, dir_b, duty_a, duty_b,
        input  in_a, in_b, pwm_a, pwm_b, period_tick, dead_a, dead_b
    );

    modport slave (
        input  dir_a, dir_b, duty_a, duty_b,
        output in_a, in_b, pwm_a, pwm_b, period_tick, dead_a, dead_b
    );
endinterface

// File: rtl/motor_pwm_stage.sv
// Dual H-bridge PWM stage. A shared free-running counter defines the PWM
// period; each driver has its own RUN/DEAD state machine that inserts a dead
// time (IN=00, PWM=0) on every direction change, and latches its duty factor
// only at the period wrap so the waveform never glitches mid-period.
// Optional feature macro: SOFT_START_EN (duty ramps by RAMP_STEP per period and
// restarts from 0 after every dead time).

module motor_pwm_drv #(
    parameter logic [11:0] PWM_TOP     = 12'd999,
    parameter int          DEAD_CYCLES = 16,
    parameter logic [11:0] RAMP_STEP   = 12'd50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  dir,
    input  logic [11:0] duty,
    input  logic [11:0] cnt,
    input  logic        wrap,
    output logic [1:0]  in_pins,
    output logic        pwm,
    output logic        dead
);
    localparam int              DCW         = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DCW-1:0]  DEAD_RELOAD = DCW'(DEAD_CYCLES - 1);
    localparam logic [11:0]     FULL_DUTY   = PWM_TOP + 12'd1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } drv_state_t;

    drv_state_t     state_r, state_nxt_s;
    logic [1:0]     dir_norm_s;
    logic [1:0]     dir_cur_r, dir_cur_nxt_s;
    logic [1:0]     dir_tgt_r, dir_tgt_nxt_s;
    logic [DCW-1:0] dead_cnt_r, dead_cnt_nxt_s;
    logic [11:0]    duty_lat_r, duty_lat_nxt_s;
    logic [1:0]     in_nxt_s;
    logic           pwm_nxt_s;
    logic           dead_nxt_s;
    logic           drive_s;

    // Anything above a full period is simply 100 % on.
    function automatic logic [11:0] clamp_duty(input logic [11:0] d);
        if (d > FULL_DUTY) begin
            return FULL_DUTY;
        end else begin
            return d;
        end
    endfunction

    assign dir_norm_s = (dir == 2'b11) ? 2'b00 : dir;

    // Direction FSM: leave RUN on any mismatch, restart the dead timer if the
    // requested direction moves again, adopt the new direction when it expires.
    always_comb begin
        state_nxt_s    = state_r;
        dir_cur_nxt_s  = dir_cur_r;
        dir_tgt_nxt_s  = dir_tgt_r;
        dead_cnt_nxt_s = dead_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (dir_norm_s != dir_cur_r) begin
                    state_nxt_s    = ST_DEAD;
                    dead_cnt_nxt_s = DEAD_RELOAD;
                    dir_tgt_nxt_s  = dir_norm_s;
                end else begin
                    state_nxt_s    = ST_RUN;
                end
            end
            ST_DEAD: begin
                if (dir_norm_s != dir_tgt_r) begin
                    dead_cnt_nxt_s = DEAD_RELOAD;
                    dir_tgt_nxt_s  = dir_norm_s;
                end else if (dead_cnt_r == {DCW{1'b0}}) begin
                    dir_cur_nxt_s  = dir_norm_s;
                    state_nxt_s    = ST_RUN;
                end else begin
                    dead_cnt_nxt_s = dead_cnt_r - DCW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

`ifdef SOFT_START_EN
    logic [11:0] duty_tgt_s;
    assign duty_tgt_s = clamp_duty(duty);

    // Soft start: held at 0 through dead time, then slews toward the target
    // by at most one ramp step at each period wrap.
    always_comb begin
        duty_lat_nxt_s = duty_lat_r;
        if (state_nxt_s == ST_DEAD) begin
            duty_lat_nxt_s = 12'd0;
        end else if (wrap) begin
            if (duty_tgt_s > duty_lat_r) begin
                if ((duty_tgt_s - duty_lat_r) > RAMP_STEP) begin
                    duty_lat_nxt_s = duty_lat_r + RAMP_STEP;
                end else begin
                    duty_lat_nxt_s = duty_tgt_s;
                end
            end else begin
                if ((duty_lat_r - duty_tgt_s) > RAMP_STEP) begin
                    duty_lat_nxt_s = duty_lat_r - RAMP_STEP;
                end else begin
                    duty_lat_nxt_s = duty_tgt_s;
                end
            end
        end else begin
            duty_lat_nxt_s = duty_lat_r;
        end
    end
`else
    // The ramp step has no role without soft start.
    logic [11:0] unused_ramp_step_s;
    assign unused_ramp_step_s = RAMP_STEP;

    // Duty is sampled only at the wrap so a period is never cut short.
    always_comb begin
        duty_lat_nxt_s = duty_lat_r;
        if (wrap) begin
            duty_lat_nxt_s = clamp_duty(duty);
        end else begin
            duty_lat_nxt_s = duty_lat_r;
        end
    end
`endif

    // Output decode from the next state so IN/PWM drop on the same edge the
    // dead time starts and return on the edge it ends.
    always_comb begin
        drive_s    = (state_nxt_s == ST_RUN) &&
                     ((dir_cur_nxt_s == 2'b10) || (dir_cur_nxt_s == 2'b01));
        in_nxt_s   = (state_nxt_s == ST_RUN) ? dir_cur_nxt_s : 2'b00;
        pwm_nxt_s  = drive_s && (cnt < duty_lat_r);
        dead_nxt_s = (state_nxt_s == ST_DEAD);
    end

    // State, duty latch and registered bridge outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            dir_cur_r  <= 2'b00;
            dir_tgt_r  <= 2'b00;
            dead_cnt_r <= {DCW{1'b0}};
            duty_lat_r <= 12'd0;
            in_pins    <= 2'b00;
            pwm        <= 1'b0;
            dead       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            dir_cur_r  <= dir_cur_nxt_s;
            dir_tgt_r  <= dir_tgt_nxt_s;
            dead_cnt_r <= dead_cnt_nxt_s;
            duty_lat_r <= duty_lat_nxt_s;
            in_pins    <= in_nxt_s;
            pwm        <= pwm_nxt_s;
            dead       <= dead_nxt_s;
        end
    end
endmodule

module motor_pwm_stage #(
    parameter logic [11:0] PWM_TOP     = 12'd999,
    parameter int          DEAD_CYCLES = 16,
    parameter logic [11:0] RAMP_STEP   = 12'd50
) (
    input  logic              clk,
    input  logic              rst,
    motor_pwm_stage_if.slave  bus
);
    logic [11:0] cnt_r;
    logic        wrap_s;
    logic        period_tick_r;
    logic [1:0]  in_a_s, in_b_s;
    logic        pwm_a_s, pwm_b_s;
    logic        dead_a_s, dead_b_s;

    assign wrap_s = (cnt_r == PWM_TOP);

    // Free-running period counter and its registered wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r         <= 12'd0;
            period_tick_r <= 1'b0;
        end else begin
            period_tick_r <= wrap_s;
            if (wrap_s) begin
                cnt_r <= 12'd0;
            end else begin
                cnt_r <= cnt_r + 12'd1;
            end
        end
    end

    motor_pwm_drv #(
        .PWM_TOP(PWM_TOP), .DEAD_CYCLES(DEAD_CYCLES), .RAMP_STEP(RAMP_STEP)
    ) u_drv_a (
        .clk(clk), .rst(rst), .dir(bus.dir_a), .duty(bus.duty_a),
        .cnt(cnt_r), .wrap(wrap_s),
        .in_pins(in_a_s), .pwm(pwm_a_s), .dead(dead_a_s)
    );

    motor_pwm_drv #(
        .PWM_TOP(PWM_TOP), .DEAD_CYCLES(DEAD_CYCLES), .RAMP_STEP(RAMP_STEP)
    ) u_drv_b (
        .clk(clk), .rst(rst), .dir(bus.dir_b), .duty(bus.duty_b),
        .cnt(cnt_r), .wrap(wrap_s),
        .in_pins(in_b_s), .pwm(pwm_b_s), .dead(dead_b_s)
    );

    assign bus.in_a        = in_a_s;
    assign bus.in_b        = in_b_s;
    assign bus.pwm_a       = pwm_a_s;
    assign bus.pwm_b       = pwm_b_s;
    assign bus.dead_a      = dead_a_s;
    assign bus.dead_b      = dead_b_s;
    assign bus.period_tick = period_tick_r;
endmodule
